// File: rtl/tl_channel_monitor_pkg.sv
// Shared types and helpers for the TileLink channel monitor.
// Holds the FSM state enum, channel codes and the size-to-beats rule.
package tl_channel_monitor_pkg;

  typedef enum logic [1:0] {StIdle, StBeats, StSkip} state_e;

  localparam logic [7:0] ChanA = 8'd0;
  localparam logic [7:0] ChanB = 8'd1;
  localparam logic [7:0] ChanC = 8'd2;
  localparam logic [7:0] ChanD = 8'd3;
  localparam logic [7:0] ChanE = 8'd4;

  localparam int unsigned BeatIdxW = 2;

  // Beats per message: data-less or <= 8 bytes is one beat, 16 bytes two, larger four.
  function automatic logic [2:0] size_to_beats(input logic has_data, input logic [2:0] size);
    if (!has_data || size <= 3'd3) begin
      return 3'd1;
    end else if (size == 3'd4) begin
      return 3'd2;
    end else begin
      return 3'd4;
    end
  endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// Beat index tracker for a multi-beat message.
// Loaded on the first beat; flags the final beat of the message.
module tl_beat_counter
  import tl_channel_monitor_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic [2:0]          beats,
  input  logic                advance,
  output logic [BeatIdxW-1:0] beat_idx,
  output logic                last
);

  logic [BeatIdxW-1:0] idx_q;
  logic [BeatIdxW-1:0] last_idx_q;

  // The loading beat occupies slot 0, so the next beat to arrive is slot 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q      <= '0;
      last_idx_q <= '0;
    end else if (load) begin
      idx_q      <= BeatIdxW'(1);
      last_idx_q <= BeatIdxW'(beats - 3'd1);
    end else if (advance) begin
      idx_q <= idx_q + BeatIdxW'(1);
    end
  end

  assign beat_idx = idx_q;
  assign last     = (idx_q == last_idx_q);

endmodule

// File: rtl/tl_channel_monitor.sv
// Passive TileLink channel monitor: captures header, stamp and up to four data
// beats per message and presents one record per message with a single-cycle strobe.
module tl_channel_monitor
  import tl_channel_monitor_pkg::*;
#(
  parameter int unsigned CHANNEL   = 0,
  parameter int unsigned MAX_BEATS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        log_enable,
  input  logic        in_valid,
  input  logic        in_ready,
  input  logic [2:0]  in_opcode,
  input  logic [2:0]  in_param,
  input  logic [2:0]  in_size,
  input  logic [7:0]  in_source,
  input  logic [7:0]  in_sink,
  input  logic [63:0] in_address,
  input  logic [63:0] in_user,
  input  logic [63:0] in_echo,
  input  logic        in_has_data,
  input  logic [63:0] in_data,
  output logic        en,
  output logic [7:0]  data_opcode,
  output logic [7:0]  data_param,
  output logic [7:0]  data_source,
  output logic [7:0]  data_sink,
  output logic [7:0]  data_channel,
  output logic [63:0] data_address,
  output logic [63:0] data_user,
  output logic [63:0] data_echo,
  output logic [63:0] data_data_0,
  output logic [63:0] data_data_1,
  output logic [63:0] data_data_2,
  output logic [63:0] data_data_3,
  output logic [63:0] stamp,
  output logic        proto_err
);

  state_e state_q, state_d;
  logic fire, hdr_load, beat_wr, emit, last;
  logic [2:0] beats;
  logic [BeatIdxW-1:0] beat_idx;
  logic [63:0] cnt_q;

  logic [2:0]  cap_opcode_q, cap_param_q;
  logic [7:0]  cap_source_q, cap_sink_q;
  logic [63:0] cap_address_q, cap_user_q, cap_echo_q, cap_stamp_q;
  logic [63:0] cap_data_q [MAX_BEATS];

  logic [2:0]  rec_opcode, rec_param;
  logic [7:0]  rec_source, rec_sink;
  logic [63:0] rec_address, rec_user, rec_echo, rec_stamp;
  logic [63:0] rec_data [MAX_BEATS];

  logic        en_q, proto_err_q;
  logic [7:0]  out_opcode_q, out_param_q, out_source_q, out_sink_q, out_channel_q;
  logic [63:0] out_address_q, out_user_q, out_echo_q, out_stamp_q;
  logic [63:0] out_data_q [MAX_BEATS];

  assign fire  = in_valid & in_ready;
  assign beats = size_to_beats(in_has_data, in_size);

  tl_beat_counter u_beat_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (hdr_load),
    .beats    (beats),
    .advance  (fire && (state_q != StIdle)),
    .beat_idx (beat_idx),
    .last     (last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:         if (fire && beats != 3'd1) state_d = log_enable ? StBeats : StSkip;
      StBeats, StSkip: if (fire && last) state_d = StIdle;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    hdr_load = 1'b0;
    beat_wr  = 1'b0;
    emit     = 1'b0;
    unique case (state_q)
      StIdle: begin
        hdr_load = fire;
        emit     = fire && log_enable && (beats == 3'd1);
      end
      StBeats: begin
        beat_wr = fire;
        emit    = fire && last;
      end
      default: ;
    endcase
  end

  // Record as it will appear at the strobe: a one-beat message bypasses the capture regs.
  always_comb begin
    rec_opcode  = cap_opcode_q;
    rec_param   = cap_param_q;
    rec_source  = cap_source_q;
    rec_sink    = cap_sink_q;
    rec_address = cap_address_q;
    rec_user    = cap_user_q;
    rec_echo    = cap_echo_q;
    rec_stamp   = cap_stamp_q;
    for (int i = 0; i < MAX_BEATS; i++) begin
      rec_data[i] = (beat_idx == BeatIdxW'(i)) ? in_data : cap_data_q[i];
    end
    if (state_q == StIdle) begin
      rec_opcode  = in_opcode;
      rec_param   = in_param;
      rec_source  = in_source;
      rec_sink    = in_sink;
      rec_address = in_address;
      rec_user    = in_user;
      rec_echo    = in_echo;
      rec_stamp   = cnt_q;
      for (int i = 0; i < MAX_BEATS; i++) rec_data[i] = '0;
      rec_data[0] = in_has_data ? in_data : '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q         <= '0;
      cap_opcode_q  <= '0;
      cap_param_q   <= '0;
      cap_source_q  <= '0;
      cap_sink_q    <= '0;
      cap_address_q <= '0;
      cap_user_q    <= '0;
      cap_echo_q    <= '0;
      cap_stamp_q   <= '0;
      for (int i = 0; i < MAX_BEATS; i++) cap_data_q[i] <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 64'd1;
      if (hdr_load) begin
        cap_opcode_q  <= in_opcode;
        cap_param_q   <= in_param;
        cap_source_q  <= in_source;
        cap_sink_q    <= in_sink;
        cap_address_q <= in_address;
        cap_user_q    <= in_user;
        cap_echo_q    <= in_echo;
        cap_stamp_q   <= cnt_q;
        for (int i = 0; i < MAX_BEATS; i++) cap_data_q[i] <= rec_data[i];
      end
      if (beat_wr) begin
        cap_data_q[beat_idx] <= in_data;
        if (in_opcode != cap_opcode_q || in_source != cap_source_q ||
            in_address != cap_address_q) begin
          proto_err_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      en_q          <= 1'b0;
      out_opcode_q  <= '0;
      out_param_q   <= '0;
      out_source_q  <= '0;
      out_sink_q    <= '0;
      out_channel_q <= '0;
      out_address_q <= '0;
      out_user_q    <= '0;
      out_echo_q    <= '0;
      out_stamp_q   <= '0;
      for (int i = 0; i < MAX_BEATS; i++) out_data_q[i] <= '0;
    end else begin
      en_q <= emit;
      if (emit) begin
        out_opcode_q  <= {5'b0, rec_opcode};
        out_param_q   <= {5'b0, rec_param};
        out_source_q  <= rec_source;
        out_sink_q    <= rec_sink;
        out_channel_q <= 8'(CHANNEL);
        out_address_q <= rec_address;
        out_user_q    <= rec_user;
        out_echo_q    <= rec_echo;
        out_stamp_q   <= rec_stamp;
        for (int i = 0; i < MAX_BEATS; i++) out_data_q[i] <= rec_data[i];
      end
    end
  end

  assign en           = en_q;
  assign proto_err    = proto_err_q;
  assign data_opcode  = out_opcode_q;
  assign data_param   = out_param_q;
  assign data_source  = out_source_q;
  assign data_sink    = out_sink_q;
  assign data_channel = out_channel_q;
  assign data_address = out_address_q;
  assign data_user    = out_user_q;
  assign data_echo    = out_echo_q;
  assign data_data_0  = out_data_q[0];
  assign data_data_1  = out_data_q[1];
  assign data_data_2  = out_data_q[2];
  assign data_data_3  = out_data_q[3];
  assign stamp        = out_stamp_q;

endmodule

// File: tb/tb_tl_channel_monitor.sv
// Self-checking bench for tl_channel_monitor: a message-level reference model checks
// every cycle, plus a vector table and directed multi-cycle sequences.
module tb_tl_channel_monitor;

  localparam int unsigned TbChannel = 2;

  logic        clock, reset, log_enable, in_valid, in_ready, in_has_data;
  logic [2:0]  in_opcode, in_param, in_size;
  logic [7:0]  in_source, in_sink;
  logic [63:0] in_address, in_user, in_echo, in_data;
  logic        en, proto_err;
  logic [7:0]  data_opcode, data_param, data_source, data_sink, data_channel;
  logic [63:0] data_address, data_user, data_echo, stamp;
  logic [63:0] data_data_0, data_data_1, data_data_2, data_data_3;

  int n_checks = 0;
  int n_fail   = 0;

  tl_channel_monitor #(
    .CHANNEL   (TbChannel),
    .MAX_BEATS (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .log_enable   (log_enable),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_param     (in_param),
    .in_size      (in_size),
    .in_source    (in_source),
    .in_sink      (in_sink),
    .in_address   (in_address),
    .in_user      (in_user),
    .in_echo      (in_echo),
    .in_has_data  (in_has_data),
    .in_data      (in_data),
    .en           (en),
    .data_opcode  (data_opcode),
    .data_param   (data_param),
    .data_source  (data_source),
    .data_sink    (data_sink),
    .data_channel (data_channel),
    .data_address (data_address),
    .data_user    (data_user),
    .data_echo    (data_echo),
    .data_data_0  (data_data_0),
    .data_data_1  (data_data_1),
    .data_data_2  (data_data_2),
    .data_data_3  (data_data_3),
    .stamp        (stamp),
    .proto_err    (proto_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (message level) ----------------
  // Record layout: opcode, param, source, sink, channel, address, user, echo, d0..d3, stamp.
  string names [13] = '{"opcode", "param", "source", "sink", "channel", "address", "user",
                        "echo", "data0", "data1", "data2", "data3", "stamp"};
  logic [63:0] m_cyc;
  bit          m_in_msg, m_log, m_en, m_perr;
  int          m_need;
  logic [2:0]  m_op;
  logic [7:0]  m_src;
  logic [63:0] m_addr;
  logic [63:0] m_hdr [13];
  logic [63:0] m_rec [13];
  logic [63:0] m_beats [$];

  function automatic int ref_beats(input logic hd, input logic [2:0] sz);
    if (!hd || sz <= 3'd3) return 1;
    return (sz == 3'd4) ? 2 : 4;
  endfunction

  task automatic model_clear();
    m_cyc = '0;
    m_in_msg = 0;
    m_en = 0;
    m_perr = 0;
    m_need = 0;
    for (int i = 0; i < 13; i++) m_rec[i] = '0;
    m_beats.delete();
  endtask

  task automatic model_edge();
    m_en = 0;
    if (in_valid && in_ready) begin
      if (!m_in_msg) begin
        m_in_msg = 1;
        m_log    = log_enable;
        m_need   = ref_beats(in_has_data, in_size);
        m_op     = in_opcode;
        m_src    = in_source;
        m_addr   = in_address;
        m_hdr    = '{64'(in_opcode), 64'(in_param), 64'(in_source), 64'(in_sink),
                     64'(TbChannel), in_address, in_user, in_echo,
                     64'd0, 64'd0, 64'd0, 64'd0, m_cyc};
        m_beats.delete();
        m_beats.push_back(in_has_data ? in_data : 64'd0);
      end else begin
        if (m_log && (in_opcode != m_op || in_source != m_src || in_address != m_addr))
          m_perr = 1;
        m_beats.push_back(in_data);
      end
      if (m_beats.size() == m_need) begin
        m_in_msg = 0;
        if (m_log) begin
          m_rec = m_hdr;
          for (int i = 0; i < m_beats.size(); i++) m_rec[8 + i] = m_beats[i];
          m_en = 1;
        end
      end
    end
    m_cyc = m_cyc + 64'd1;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) model_clear();
      else model_edge();
    end
  end

  initial begin : cycle_checker
    logic [63:0] got [13];
    forever begin
      @(negedge clock);
      got = '{64'(data_opcode), 64'(data_param), 64'(data_source), 64'(data_sink),
              64'(data_channel), data_address, data_user, data_echo,
              data_data_0, data_data_1, data_data_2, data_data_3, stamp};
      chk("model_en", 64'(en), 64'(m_en));
      chk("model_proto_err", 64'(proto_err), 64'(m_perr));
      for (int i = 0; i < 13; i++) chk({"model_", names[i]}, got[i], m_rec[i]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic le, input logic [2:0] op, input logic [2:0] sz,
                       input logic hd, input logic [7:0] src, input logic [63:0] addr,
                       input logic [63:0] d);
    in_valid    = 1'b1;
    in_ready    = 1'b1;
    log_enable  = le;
    in_opcode   = op;
    in_size     = sz;
    in_has_data = hd;
    in_source   = src;
    in_address  = addr;
    in_data     = d;
  endtask

  typedef struct {
    logic [2:0]  opcode;
    logic [2:0]  size;
    logic        has_data;
    logic        log_en;
    logic [63:0] addr;
    logic [63:0] data;
    logic        exp_en;
    logic [63:0] exp_d0;
    logic [63:0] exp_addr;
  } vec_t;

  vec_t tbl [8];
  logic [63:0] s;

  initial begin
    // back-to-back single-beat messages; non-logged entries leave the previous record held
    tbl[0] = '{3'd4, 3'd2, 1'b1, 1'b1, 64'h100, 64'hAAAA, 1'b1, 64'hAAAA, 64'h100};
    tbl[1] = '{3'd4, 3'd3, 1'b1, 1'b1, 64'h104, 64'hBBBB, 1'b1, 64'hBBBB, 64'h104};
    tbl[2] = '{3'd0, 3'd7, 1'b0, 1'b1, 64'h200, 64'hCCCC, 1'b1, 64'h0,    64'h200};
    tbl[3] = '{3'd4, 3'd1, 1'b1, 1'b0, 64'h300, 64'hDDDD, 1'b0, 64'h0,    64'h200};
    tbl[4] = '{3'd1, 3'd0, 1'b1, 1'b1, 64'h308, 64'hEEEE, 1'b1, 64'hEEEE, 64'h308};
    tbl[5] = '{3'd4, 3'd5, 1'b0, 1'b0, 64'h400, 64'h1,    1'b0, 64'hEEEE, 64'h308};
    tbl[6] = '{3'd0, 3'd3, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF,
               1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF8};
    tbl[7] = '{3'd4, 3'd4, 1'b0, 1'b1, 64'h10,  64'h5,    1'b1, 64'h0,    64'h10};

    reset = 1'b0; log_enable = 1'b0; in_valid = 1'b0; in_ready = 1'b0;
    in_opcode = '0; in_param = 3'd1; in_size = '0; in_source = '0; in_sink = 8'h5A;
    in_address = '0; in_user = 64'h1234; in_echo = 64'hE0; in_has_data = 1'b0; in_data = '0;
    step();
    chk("reset_en", 64'(en), 64'd0);
    chk("reset_stamp", stamp, 64'd0);
    step();
    reset = 1'b1;

    // Get fired at cycle 10
    repeat (10) step();
    drive(1'b1, 3'd4, 3'd2, 1'b0, 8'h12, 64'h80, 64'hDEAD);
    step();
    chk("get_en", 64'(en), 64'd1);
    chk("get_stamp", stamp, 64'd10);
    chk("get_addr", data_address, 64'h80);
    chk("get_slots", data_data_0 | data_data_1 | data_data_2 | data_data_3, 64'd0);
    chk("get_channel", 64'(data_channel), 64'(TbChannel));
    in_valid = 1'b0;
    step();
    chk("get_en_once", 64'(en), 64'd0);

    // 4 beats with a ready stall after beat 2
    s = m_cyc;
    drive(1'b1, 3'd0, 3'd6, 1'b1, 8'h12, 64'h1000, 64'h11);
    step(); chk("b4_en1", 64'(en), 64'd0);
    in_data = 64'h22;
    step(); chk("b4_en2", 64'(en), 64'd0);
    in_ready = 1'b0; in_data = 64'h99;
    step(); chk("b4_stall", 64'(en), 64'd0);
    in_ready = 1'b1; in_data = 64'h33;
    step(); chk("b4_en3", 64'(en), 64'd0);
    in_data = 64'h44;
    step();
    chk("b4_en", 64'(en), 64'd1);
    chk("b4_d0", data_data_0, 64'h11);
    chk("b4_d1", data_data_1, 64'h22);
    chk("b4_d2", data_data_2, 64'h33);
    chk("b4_d3", data_data_3, 64'h44);
    chk("b4_stamp", stamp, s);
    in_valid = 1'b0;
    step();
    chk("b4_en_once", 64'(en), 64'd0);
    chk("b4_hold", data_data_3, 64'h44);

    // size 4, log_enable dropped after beat 1
    drive(1'b1, 3'd0, 3'd4, 1'b1, 8'h12, 64'h1100, 64'hA1);
    step(); chk("b2_en1", 64'(en), 64'd0);
    log_enable = 1'b0; in_data = 64'hA2;
    step();
    chk("b2_en", 64'(en), 64'd1);
    chk("b2_d0", data_data_0, 64'hA1);
    chk("b2_d1", data_data_1, 64'hA2);
    chk("b2_d23", data_data_2 | data_data_3, 64'd0);

    // skipped 4-beat message then a 1-beat message
    for (int b = 0; b < 4; b++) begin
      drive(1'b0, 3'd0, 3'd5, 1'b1, 8'h12, 64'h1200, 64'(b + 1));
      if (b > 0) log_enable = 1'b1;
      step();
      chk($sformatf("skip_en%0d", b), 64'(en), 64'd0);
    end
    drive(1'b1, 3'd1, 3'd2, 1'b1, 8'h12, 64'h1300, 64'h55);
    step();
    chk("after_skip_en", 64'(en), 64'd1);
    chk("after_skip_d0", data_data_0, 64'h55);
    chk("after_skip_d1", data_data_1, 64'd0);

    // table: back-to-back single-beat records
    for (int k = 0; k < 8; k++) begin
      drive(tbl[k].log_en, tbl[k].opcode, tbl[k].size, tbl[k].has_data, 8'h21,
            tbl[k].addr, tbl[k].data);
      step();
      chk($sformatf("tbl%0d_en", k), 64'(en), 64'(tbl[k].exp_en));
      chk($sformatf("tbl%0d_d0", k), data_data_0, tbl[k].exp_d0);
      chk($sformatf("tbl%0d_addr", k), data_address, tbl[k].exp_addr);
    end
    in_valid = 1'b0;
    step();

    // source changes on beat 3
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, 3'd0, 3'd7, 1'b1, (b == 2) ? 8'h34 : 8'h12, 64'h2000, 64'(b + 8'hB0));
      step();
      chk($sformatf("perr_beat%0d", b), 64'(proto_err), (b >= 2) ? 64'd1 : 64'd0);
    end
    chk("perr_rec_en", 64'(en), 64'd1);
    in_valid = 1'b0;
    repeat (3) step();
    chk("perr_sticky", 64'(proto_err), 64'd1);

    // reset after beat 2 of 4
    drive(1'b1, 3'd0, 3'd5, 1'b1, 8'h12, 64'h3000, 64'hC1);
    step();
    in_data = 64'hC2;
    step();
    #1 reset = 1'b0;
    #1;
    chk("rst_en", 64'(en), 64'd0);
    chk("rst_perr", 64'(proto_err), 64'd0);
    chk("rst_stamp", stamp, 64'd0);
    chk("rst_d0", data_data_0, 64'd0);
    chk("rst_addr", data_address, 64'd0);
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    repeat (4) begin
      step();
      chk("rst_no_en", 64'(en), 64'd0);
    end
    s = m_cyc;
    drive(1'b1, 3'd4, 3'd0, 1'b1, 8'h12, 64'h500, 64'h77);
    step();
    chk("post_rst_en", 64'(en), 64'd1);
    chk("post_rst_d0", data_data_0, 64'h77);
    chk("post_rst_stamp", stamp, s);
    in_valid = 1'b0;
    step();

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if (c == 750) begin
        reset = 1'b0;
        step();
        reset = 1'b1;
      end
      if (!m_in_msg) begin
        in_opcode   = 3'($urandom);
        in_param    = 3'($urandom);
        in_size     = 3'($urandom);
        in_has_data = 1'($urandom);
        in_source   = 8'($urandom);
        in_sink     = 8'($urandom);
        in_address  = {$urandom, $urandom};
        in_user     = {$urandom, $urandom};
        in_echo     = {$urandom, $urandom};
      end else if ($urandom_range(0, 39) == 0) begin
        in_source = 8'($urandom);
      end
      in_valid   = ($urandom_range(0, 9) < 7);
      in_ready   = ($urandom_range(0, 3) != 0);
      log_enable = ($urandom_range(0, 3) != 0);
      in_data    = {$urandom, $urandom};
      step();
    end
    in_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
